// File: rtl/config_usb_pkg.sv
// rtl/config_usb_pkg.sv - shared FSM states, sync word and DFU alternate settings
package config_usb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_REQ,
    ST_WAIT,
    ST_SEND,
    ST_TRL,
    ST_DONE
  } cfg_state_e;

  localparam logic [31:0] SYNC_WORD_DEFAULT = 32'hFAB0_FAB1;
  localparam logic [2:0]  ALT_DOWNLOAD      = 3'b001;
  localparam logic [2:0]  ALT_UPLOAD        = 3'b010;

endpackage

// File: rtl/word_byte_serializer.sv
// rtl/word_byte_serializer.sv - loads a 32-bit word and emits it MSB-first as a valid/ready byte stream
// load_half starts the byte counter at 2 so only word[31:16] goes out.
module word_byte_serializer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        load_half,
  input  logic [31:0] load_word,
  input  logic        abort,
  input  logic        tready,
  output logic [7:0]  tdata,
  output logic        tvalid,
  output logic        last_byte
);

  logic [31:0] shift_q;
  logic [1:0]  cnt_q;
  logic        valid_q;

  // load wins over a completing transfer so the next word follows with no gap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= 32'h0;
      cnt_q   <= 2'd0;
      valid_q <= 1'b0;
    end else if (abort) begin
      valid_q <= 1'b0;
    end else if (load) begin
      shift_q <= load_word;
      cnt_q   <= load_half ? 2'd2 : 2'd0;
      valid_q <= 1'b1;
    end else if (valid_q && tready) begin
      shift_q <= {shift_q[23:0], 8'h00};
      cnt_q   <= cnt_q + 2'd1;
      if (cnt_q == 2'd3) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign tdata     = shift_q[31:24];
  assign tvalid    = valid_q;
  assign last_byte = valid_q && (cnt_q == 2'd3);

endmodule

// File: rtl/config_readback_usb.sv
// rtl/config_readback_usb.sv - DFU upload path: reads config words and streams header, payload, optional checksum
// CONFIG_READBACK_CHECKSUM_EN adds a 16-bit payload byte sum sent as a 2-byte trailer.
module config_readback_usb
  import config_usb_pkg::*;
#(
  parameter int unsigned WORD_COUNT  = 256,
  parameter logic [2:0]  ALT_SETTING = ALT_UPLOAD,
  parameter logic [31:0] SYNC_WORD   = SYNC_WORD_DEFAULT
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        dfu_mode_i,
  input  logic [2:0]  dfu_alt_i,
  input  logic        dfu_in_en_i,
  output logic [7:0]  dfu_in_data_o,
  output logic        dfu_in_valid_o,
  input  logic        dfu_in_ready_i,
  output logic        read_req_o,
  output logic [15:0] read_addr_o,
  input  logic [31:0] read_data_i,
  input  logic        read_valid_i,
  output logic        busy_o,
  output logic        done_o
);

  localparam logic [15:0] LAST_IDX = 16'(WORD_COUNT - 1);

  cfg_state_e  state_q, state_d;
  logic        en, en_q, en_rise;
  logic        busy, start, abort_req;
  logic [15:0] idx_q;
  logic        done_q;
  logic        stale_q;
  logic        ser_load, ser_half, ser_abort, ser_last, fire_last;
  logic [31:0] ser_word;

  assign en        = dfu_mode_i && dfu_in_en_i && (dfu_alt_i == ALT_SETTING);
  assign en_rise   = en && !en_q;
  assign busy      = !(state_q inside {ST_IDLE, ST_DONE});
  assign start     = (state_q == ST_IDLE) && en_rise;
  assign abort_req = busy && !en;
  assign fire_last = ser_last && dfu_in_ready_i;

`ifdef CONFIG_READBACK_CHECKSUM_EN
  logic [15:0] sum_q, sum_next;

  assign sum_next = sum_q + (((state_q == ST_SEND) && dfu_in_valid_o && dfu_in_ready_i)
                             ? {8'h00, dfu_in_data_o} : 16'h0000);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sum_q <= 16'h0000;
    end else if (start) begin
      sum_q <= 16'h0000;
    end else begin
      sum_q <= sum_next;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    ser_load  = 1'b0;
    ser_half  = 1'b0;
    ser_abort = 1'b0;
    ser_word  = SYNC_WORD;
    if (abort_req) begin
      state_d   = ST_IDLE;
      ser_abort = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: if (en_rise) begin
          state_d  = ST_HDR;
          ser_load = 1'b1;
        end
        ST_HDR: if (fire_last) state_d = ST_REQ;
        ST_REQ: state_d = ST_WAIT;
        ST_WAIT: if (read_valid_i && !stale_q) begin
          state_d  = ST_SEND;
          ser_load = 1'b1;
          ser_word = read_data_i;
        end
        ST_SEND: if (fire_last) begin
          if (idx_q == LAST_IDX) begin
`ifdef CONFIG_READBACK_CHECKSUM_EN
            state_d  = ST_TRL;
            ser_load = 1'b1;
            ser_half = 1'b1;
            ser_word = {sum_next, 16'h0000};
`else
            state_d  = ST_DONE;
`endif
          end else begin
            state_d = ST_REQ;
          end
        end
`ifdef CONFIG_READBACK_CHECKSUM_EN
        ST_TRL: if (fire_last) state_d = ST_DONE;
`endif
        ST_DONE: if (!en) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // en_q resets high so an enable already high at reset release is not a start
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
      en_q    <= 1'b1;
      idx_q   <= 16'h0000;
      done_q  <= 1'b0;
      stale_q <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en;
      if (start) begin
        idx_q  <= 16'h0000;
        done_q <= 1'b0;
      end else begin
        if ((state_q == ST_SEND) && (state_d == ST_REQ)) idx_q <= idx_q + 16'd1;
        if ((state_d == ST_DONE) && (state_q != ST_DONE)) done_q <= 1'b1;
      end
      // a read abandoned by an abort still owes one response; swallow it
      if ((state_q == ST_REQ) && !en) begin
        stale_q <= 1'b1;
      end else if (read_valid_i) begin
        stale_q <= 1'b0;
      end else if ((state_q == ST_WAIT) && !en) begin
        stale_q <= 1'b1;
      end
    end
  end

  word_byte_serializer u_ser (
    .clk       (clk_i),
    .rst_n     (reset_n_i),
    .load      (ser_load),
    .load_half (ser_half),
    .load_word (ser_word),
    .abort     (ser_abort),
    .tready    (dfu_in_ready_i),
    .tdata     (dfu_in_data_o),
    .tvalid    (dfu_in_valid_o),
    .last_byte (ser_last)
  );

  assign read_req_o  = (state_q == ST_REQ);
  assign read_addr_o = idx_q;
  assign busy_o      = busy;
  assign done_o      = done_q;

endmodule
